mpc_mac_pipe: RTL and testbench

//  Parametrised pipelined signed multiply / multiply-accumulate unit for the MPC datapath.

---
 rtl/mpc_mac_pipe_if.sv | 29 ++
 rtl/mpc_mac_pipe.sv | 147 ++++++++++++++
 tb/tb_mpc_mac_pipe.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mpc_mac_pipe_if.sv
// Handshake/data bundle for mpc_mac_pipe: beat inputs, control and the rescaled result.
interface mpc_mac_pipe_if #(
  parameter int A_W   = 21,
  parameter int B_W   = 10,
  parameter int OUT_W = 31
);
  logic                    ce;
  logic                    in_valid;
  logic signed [A_W-1:0]   a;
  logic signed [B_W-1:0]   b;
  logic                    mode;
  logic                    acc_first;
  logic                    acc_last;
  logic                    ovf_clr;
  logic                    out_valid;
  logic signed [OUT_W-1:0] q;
  logic                    sat;
  logic                    ovf_sticky;

  modport master (
    output ce, in_valid, a, b, mode, acc_first, acc_last, ovf_clr,
    input  out_valid, q, sat, ovf_sticky
  );

  modport slave (
    input  ce, in_valid, a, b, mode, acc_first, acc_last, ovf_clr,
    output out_valid, q, sat, ovf_sticky
  );
endinterface

// File: rtl/mpc_mac_pipe.sv
// Pipelined signed multiply / multiply-accumulate with round-half-up rescale and saturation.
// Accumulator and output registers load on the same edge, giving IN_STAGES+MUL_STAGES+1 latency.
module mpc_mac_pipe #(
  parameter int A_W        = 21,
  parameter int B_W        = 10,
  parameter int ACC_W      = 40,
  parameter int OUT_W      = 31,
  parameter int SHIFT      = 0,
  parameter int IN_STAGES  = 1,
  parameter int MUL_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  mpc_mac_pipe_if.slave bus
);
  localparam int P_W = A_W + B_W;
  localparam int R_W = ACC_W + 1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [R_W-1:0]   Q_MAX   = {{(R_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [R_W-1:0]   Q_MIN   = {{(R_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [R_W-1:0]   RND     =
    (SHIFT == 0) ? '0 : R_W'(1) << ((SHIFT == 0) ? 0 : SHIFT - 1);

  // control bundle: {valid, mode, first, last}
  logic signed [A_W-1:0] a_q      [IN_STAGES];
  logic signed [B_W-1:0] b_q      [IN_STAGES];
  logic [3:0]            in_ctl_q [IN_STAGES];
  logic signed [P_W-1:0] prod_q   [MUL_STAGES];
  logic [3:0]            mul_ctl_q[MUL_STAGES];

  logic signed [P_W-1:0]   mul_a, mul_b, prod_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_next, prod_ext;
  logic                    sum_ovf_q, sum_ovf_d, sum_ovf_next;
  logic signed [R_W-1:0]   sum, rnd_sum, r;
  logic                    m_valid, m_mode, m_first, m_last, load, emit;
  logic                    out_valid_q, sat_q, sat_d, ovf_sticky_q, ovf_sticky_d;
  logic signed [OUT_W-1:0] q_q, q_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < IN_STAGES; i++) begin
        a_q[i]      <= '0;
        b_q[i]      <= '0;
        in_ctl_q[i] <= '0;
      end
    end else if (bus.ce) begin
      a_q[0]      <= bus.a;
      b_q[0]      <= bus.b;
      in_ctl_q[0] <= {bus.in_valid, bus.mode, bus.acc_first, bus.acc_last};
      for (int unsigned i = 1; i < IN_STAGES; i++) begin
        a_q[i]      <= a_q[i-1];
        b_q[i]      <= b_q[i-1];
        in_ctl_q[i] <= in_ctl_q[i-1];
      end
    end
  end

  always_comb begin
    mul_a  = P_W'(a_q[IN_STAGES-1]);
    mul_b  = P_W'(b_q[IN_STAGES-1]);
    prod_d = mul_a * mul_b;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < MUL_STAGES; i++) begin
        prod_q[i]    <= '0;
        mul_ctl_q[i] <= '0;
      end
    end else if (bus.ce) begin
      prod_q[0]    <= prod_d;
      mul_ctl_q[0] <= in_ctl_q[IN_STAGES-1];
      for (int unsigned i = 1; i < MUL_STAGES; i++) begin
        prod_q[i]    <= prod_q[i-1];
        mul_ctl_q[i] <= mul_ctl_q[i-1];
      end
    end
  end

  always_comb begin
    {m_valid, m_mode, m_first, m_last} = mul_ctl_q[MUL_STAGES-1];
    prod_ext = ACC_W'(prod_q[MUL_STAGES-1]);
    sum      = R_W'(acc_q) + R_W'(prod_ext);
    load     = ~m_mode | m_first;
    emit     = m_valid & (~m_mode | m_last);
    acc_next     = sum[ACC_W-1:0];
    sum_ovf_next = sum_ovf_q;
    if (load) begin
      acc_next     = prod_ext;
      sum_ovf_next = 1'b0;
    end else if (sum[R_W-1] ^ sum[R_W-2]) begin
      acc_next     = sum[R_W-1] ? ACC_MIN : ACC_MAX;
      sum_ovf_next = 1'b1;
    end
    acc_d     = m_valid ? acc_next : acc_q;
    sum_ovf_d = m_valid ? sum_ovf_next : sum_ovf_q;
  end

  // Rounding add is done one bit wider than the accumulator so it cannot wrap.
  always_comb begin
    rnd_sum = R_W'(acc_next) + RND;
    r       = rnd_sum >>> SHIFT;
    q_d     = r[OUT_W-1:0];
    sat_d   = sum_ovf_next;
    if (r > Q_MAX) begin
      q_d   = Q_MAX[OUT_W-1:0];
      sat_d = 1'b1;
    end else if (r < Q_MIN) begin
      q_d   = Q_MIN[OUT_W-1:0];
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      sum_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
      q_q         <= '0;
      sat_q       <= 1'b0;
    end else if (bus.ce) begin
      acc_q       <= acc_d;
      sum_ovf_q   <= sum_ovf_d;
      out_valid_q <= emit;
      if (emit) begin
        q_q   <= q_d;
        sat_q <= sat_d;
      end
    end
  end

  // Sticky flag runs independently of ce; a set coinciding with clear wins.
  always_comb ovf_sticky_d = (out_valid_q & sat_q) | (ovf_sticky_q & ~bus.ovf_clr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_sticky_q <= 1'b0;
    else     ovf_sticky_q <= ovf_sticky_d;
  end

  always_comb begin
    bus.out_valid  = out_valid_q;
    bus.q          = q_q;
    bus.sat        = sat_q;
    bus.ovf_sticky = ovf_sticky_q;
  end
endmodule

// File: tb/tb_mpc_mac_pipe.sv
// Scoreboard bench for mpc_mac_pipe: default, OUT_W=16 and SHIFT=4 instances share clk/rst/ce.
module tb_mpc_mac_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b1;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  mpc_mac_pipe_if #(.A_W(21), .B_W(10), .OUT_W(31)) b0 ();
  mpc_mac_pipe_if #(.A_W(21), .B_W(10), .OUT_W(16)) b1 ();
  mpc_mac_pipe_if #(.A_W(21), .B_W(10), .OUT_W(31)) b2 ();

  mpc_mac_pipe #(.OUT_W(31), .SHIFT(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
  mpc_mac_pipe #(.OUT_W(16), .SHIFT(0)) u1 (.clk(clk), .rst(rst), .bus(b1));
  mpc_mac_pipe #(.OUT_W(31), .SHIFT(4)) u2 (.clk(clk), .rst(rst), .bus(b2));

  assign b0.ce = ce;  assign b1.ce = ce;  assign b2.ce = ce;
  assign b0.ovf_clr = clr;  assign b1.ovf_clr = clr;  assign b2.ovf_clr = clr;

  typedef struct { longint q; bit sat; int cyc; } exp_t;
  exp_t sb0[$];
  exp_t sb1[$];
  exp_t sb2[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit adv    = 1'b0;

  // ce-qualified cycle count; adv marks edges where the outputs may have changed
  always @(posedge clk) begin
    adv = ce;
    if (ce) cyc++;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic mon(input int inst, input longint qv, input bit sv);
    exp_t e;
    int   n;
    case (inst)
      0:       n = sb0.size();
      1:       n = sb1.size();
      default: n = sb2.size();
    endcase
    if (n == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_pulse%0d: got q=%0d expected no out_valid", inst, qv);
      return;
    end
    case (inst)
      0:       e = sb0.pop_front();
      1:       e = sb1.pop_front();
      default: e = sb2.pop_front();
    endcase
    chk($sformatf("q%0d", inst), qv, e.q);
    chk($sformatf("sat%0d", inst), longint'(sv), longint'(e.sat));
    chk($sformatf("latency%0d", inst), longint'(cyc), longint'(e.cyc));
  endtask

  always @(negedge clk) if (adv && b0.out_valid === 1'b1) mon(0, longint'($signed(b0.q)), b0.sat);
  always @(negedge clk) if (adv && b1.out_valid === 1'b1) mon(1, longint'($signed(b1.q)), b1.sat);
  always @(negedge clk) if (adv && b2.out_valid === 1'b1) mon(2, longint'($signed(b2.q)), b2.sat);

  task automatic all_idle();
    b0.in_valid = 1'b0;
    b1.in_valid = 1'b0;
    b2.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      all_idle();
    end
  endtask

  task automatic beat(input int inst, input int av, input int bv, input bit m, input bit f,
                      input bit l, input longint eq, input bit es);
    exp_t e;
    @(posedge clk); #1;
    all_idle();
    e.q   = eq;
    e.sat = es;
    e.cyc = cyc + 4;
    case (inst)
      0: begin
        b0.in_valid = 1'b1; b0.a = 21'(av); b0.b = 10'(bv);
        b0.mode = m; b0.acc_first = f; b0.acc_last = l;
        if (!m || l) sb0.push_back(e);
      end
      1: begin
        b1.in_valid = 1'b1; b1.a = 21'(av); b1.b = 10'(bv);
        b1.mode = m; b1.acc_first = f; b1.acc_last = l;
        if (!m || l) sb1.push_back(e);
      end
      default: begin
        b2.in_valid = 1'b1; b2.a = 21'(av); b2.b = 10'(bv);
        b2.mode = m; b2.acc_first = f; b2.acc_last = l;
        if (!m || l) sb2.push_back(e);
      end
    endcase
  endtask

  initial begin
    all_idle();
    b0.a = '0; b0.b = '0; b0.mode = 1'b0; b0.acc_first = 1'b0; b0.acc_last = 1'b0;
    b1.a = '0; b1.b = '0; b1.mode = 1'b0; b1.acc_first = 1'b0; b1.acc_last = 1'b0;
    b2.a = '0; b2.b = '0; b2.mode = 1'b0; b2.acc_first = 1'b0; b2.acc_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", longint'(b0.out_valid), 0);
    chk("rst_q", longint'($signed(b0.q)), 0);
    chk("rst_sat", longint'(b0.sat), 0);
    chk("rst_ovf_sticky", longint'(b1.ovf_sticky), 0);
    rst = 1'b0;
    idle(2);

    // multiply mode, back-to-back including operand extremes
    beat(0, -3, 5, 0, 0, 0, -15, 0);
    beat(0, 7, -9, 0, 0, 0, -63, 0);
    beat(0, -1048576, -512, 0, 0, 0, 536870912, 0);
    beat(0, 1048575, 511, 0, 0, 0, 535821825, 0);
    idle(6);

    // dot product with a gap, single-beat sum, and last without first
    beat(0, 2, 3, 1, 1, 0, 0, 0);
    beat(0, 4, 5, 1, 0, 0, 0, 0);
    idle(1);
    beat(0, -1, 6, 1, 0, 1, 20, 0);
    beat(0, -7, 7, 1, 1, 1, -49, 0);
    beat(0, 10, 1, 1, 0, 1, -39, 0);
    idle(6);

    // ce stall while the beat is mid-pipeline
    beat(0, 11, 12, 0, 0, 0, 132, 0);
    idle(1);
    ce = 1'b0;
    repeat (2) @(posedge clk);
    #1 ce = 1'b1;
    idle(6);

    // saturation on the 16-bit instance, then sticky clear
    beat(1, 1000, 500, 1, 1, 0, 0, 0);
    beat(1, 1000, 500, 1, 0, 1, 32767, 1);
    beat(1, -1000, 500, 0, 0, 0, -32768, 1);
    idle(7);
    chk("ovf_sticky_set", longint'(b1.ovf_sticky), 1);
    chk("ovf_sticky_untouched", longint'(b0.ovf_sticky), 0);
    chk("q_hold", longint'($signed(b1.q)), -32768);
    chk("sat_hold", longint'(b1.sat), 1);
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    chk("ovf_sticky_clr", longint'(b1.ovf_sticky), 0);

    // SHIFT=4 round half up
    beat(2, 3, 8, 0, 0, 0, 2, 0);
    beat(2, -3, 8, 0, 0, 0, -1, 0);
    beat(2, 1, 8, 0, 0, 0, 1, 0);
    beat(2, -1, 8, 0, 0, 0, 0, 0);
    beat(2, 5, 7, 0, 0, 0, 2, 0);
    idle(6);

    // reset in the middle of a sum, then a fresh sum
    beat(0, 3, 4, 1, 1, 0, 0, 0);
    beat(0, 5, 6, 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    all_idle();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", longint'(b0.out_valid), 0);
    chk("midrst_q", longint'($signed(b0.q)), 0);
    rst = 1'b0;
    idle(6);
    chk("postrst_q", longint'($signed(b0.q)), 0);
    beat(0, 2, 2, 1, 1, 0, 0, 0);
    beat(0, 3, 3, 1, 0, 1, 13, 0);

    for (int i = 0; i < 30; i++) begin
      if (sb0.size() == 0 && sb1.size() == 0 && sb2.size() == 0) break;
      idle(1);
    end
    idle(2);
    while (sb0.size() != 0) begin
      void'(sb0.pop_front());
      checks++; errors++;
      $display("FAIL missing_pulse0: got no out_valid expected a result");
    end
    while (sb1.size() != 0) begin
      void'(sb1.pop_front());
      checks++; errors++;
      $display("FAIL missing_pulse1: got no out_valid expected a result");
    end
    while (sb2.size() != 0) begin
      void'(sb2.pop_front());
      checks++; errors++;
      $display("FAIL missing_pulse2: got no out_valid expected a result");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
